// File: rtl/wb_arb_sched.sv
// wb_arb_sched: registered Wishbone bus arbiter with an optional stall watchdog (WB_ARB_TIMEOUT_EN)
module wb_arb_sched #(
  parameter int    PORTS        = 3,
  parameter string ARB_TYPE     = "PRIORITY",
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    TIMEOUT      = 256,
  parameter int    ENC_W        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic             stb_i,
  input  logic             term_i,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [ENC_W-1:0] grant_encoded,
  output logic             tmo_err
);
  localparam bit RR = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit HI = (LSB_PRIORITY == "HIGH");
`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN, TMO} state_t;
  logic [15:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;
`else
  typedef enum logic {IDLE, OWN} state_t;
  logic unused_in;
`endif
  state_t           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [ENC_W-1:0] enc_q, enc_d, ptr_q, ptr_d, win;
  logic             hit;
  int               start, idx, nxt;
  // Pick the winner: scan from the start point in the preferred direction, nearest hit wins
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = 0;
    start = RR ? int'(ptr_q) : (HI ? 0 : PORTS - 1);
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = HI ? (start + k) % PORTS : (start - k + PORTS) % PORTS;
      if (request[idx]) begin
        win = ENC_W'(idx);
        hit = 1'b1;
      end
    end
  end
  // Next-state logic: grant in IDLE, hold until the owner drops CYC, optional watchdog abort
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    ptr_d   = ptr_q;
    nxt     = HI ? (int'(enc_q) + 1) % PORTS : (int'(enc_q) - 1 + PORTS) % PORTS;
`ifdef WB_ARB_TIMEOUT_EN
    wd_d    = '0;
    tmo_d   = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (hit) begin
        state_d = OWN;
        grant_d = PORTS'(1) << win;
        enc_d   = win;
        valid_d = 1'b1;
      end
    end else if (!request[enc_q]) begin
      state_d = IDLE;
      grant_d = '0;
      enc_d   = '0;
      valid_d = 1'b0;
      ptr_d   = RR ? ENC_W'(nxt) : '0;
    end
`ifdef WB_ARB_TIMEOUT_EN
    else if (state_q == OWN && stb_i && !term_i) begin
      if (wd_q == 16'(TIMEOUT - 1)) begin
        tmo_d   = 1'b1;
        valid_d = 1'b0;
        state_d = TMO;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end
`endif
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end
  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;
`ifdef WB_ARB_TIMEOUT_EN
  assign tmo_err       = tmo_q;
`else
  assign tmo_err       = 1'b0;
  assign unused_in     = ^{stb_i, term_i, TIMEOUT[0]};
`endif
endmodule

// File: tb/tb_wb_arb_sched.sv
// tb_wb_arb_sched: scoreboard bench for wb_arb_sched (priority, round-robin, low-priority and watchdog builds)
module tb_wb_arb_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic       stb = 1'b0;
  logic       term = 1'b0;
  logic [2:0] gr [3];
  logic       vl [3];
  logic [1:0] en [3];
  logic       tm [3];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         sel;
    int         tag;
    logic [2:0] g;
    logic       v;
    logic [1:0] e;
    logic       t;
  } exp_t;
  exp_t q[$];
  exp_t mx;

  always #5 clk = ~clk;

  wb_arb_sched #(.PORTS(3), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH"), .TIMEOUT(8)) u_pri (
    .clk(clk), .rst(rst), .request(req), .stb_i(stb), .term_i(term),
    .grant(gr[0]), .grant_valid(vl[0]), .grant_encoded(en[0]), .tmo_err(tm[0]));
  wb_arb_sched #(.PORTS(3), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH"), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst(rst), .request(req), .stb_i(stb), .term_i(term),
    .grant(gr[1]), .grant_valid(vl[1]), .grant_encoded(en[1]), .tmo_err(tm[1]));
  wb_arb_sched #(.PORTS(3), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("LOW"), .TIMEOUT(8)) u_low (
    .clk(clk), .rst(rst), .request(req), .stb_i(stb), .term_i(term),
    .grant(gr[2]), .grant_valid(vl[2]), .grant_encoded(en[2]), .tmo_err(tm[2]));

  task automatic step(input int sel, input int tag, input logic r, input logic [2:0] rq,
                      input logic s, input logic tr, input logic [2:0] g, input logic v,
                      input logic [1:0] e, input logic t);
    exp_t x;
    @(negedge clk);
    rst  = r;
    req  = rq;
    stb  = s;
    term = tr;
    x.sel = sel; x.tag = tag; x.g = g; x.v = v; x.e = e; x.t = t;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mx = q.pop_front();
      n_chk++;
      if ({gr[mx.sel], vl[mx.sel], en[mx.sel], tm[mx.sel]} !== {mx.g, mx.v, mx.e, mx.t}) begin
        n_fail++;
        $display("FAIL test%0d dut%0d @%0t: got grant=%b valid=%b enc=%0d tmo=%b, expected grant=%b valid=%b enc=%0d tmo=%b",
                 mx.tag, mx.sel, $time, gr[mx.sel], vl[mx.sel], en[mx.sel], tm[mx.sel], mx.g, mx.v, mx.e, mx.t);
      end
    end
  end

  initial begin
    step(0, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    step(1, 0, 1, 3'b111, 1, 1, 3'b000, 0, 0, 0);
    step(2, 0, 1, 3'b111, 0, 0, 3'b000, 0, 0, 0);
    // fixed priority, port 0 wins ties
    step(0, 1, 0, 3'b110, 0, 0, 3'b010, 1, 1, 0);
    step(0, 1, 0, 3'b110, 0, 0, 3'b010, 1, 1, 0);
    step(0, 1, 0, 3'b100, 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b100, 0, 0, 3'b100, 1, 2, 0);
    step(0, 1, 0, 3'b111, 0, 0, 3'b100, 1, 2, 0);
    step(0, 1, 0, 3'b011, 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b011, 0, 0, 3'b001, 1, 0, 0);
    step(0, 1, 0, 3'b000, 1, 1, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b000, 1, 1, 3'b000, 0, 0, 0);
    // round robin, each owner holds four cycles
    step(1, 2, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 3'b111, 0, 0, 3'b001, 1, 0, 0);
    step(1, 2, 0, 3'b110, 0, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 3'b111, 0, 0, 3'b010, 1, 1, 0);
    step(1, 2, 0, 3'b101, 0, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 3'b111, 0, 0, 3'b100, 1, 2, 0);
    step(1, 2, 0, 3'b011, 0, 0, 3'b000, 0, 0, 0);
    step(1, 2, 0, 3'b111, 0, 0, 3'b001, 1, 0, 0);
    step(1, 2, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    // reset during ownership of port 2 restores the pointer to 0
    step(1, 4, 0, 3'b100, 0, 0, 3'b100, 1, 2, 0);
    step(1, 4, 1, 3'b100, 0, 0, 3'b000, 0, 0, 0);
    step(1, 4, 0, 3'b111, 0, 0, 3'b001, 1, 0, 0);
    step(1, 4, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    // fixed priority, highest port wins ties
    step(2, 3, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    step(2, 3, 0, 3'b011, 0, 0, 3'b010, 1, 1, 0);
    step(2, 3, 0, 3'b011, 0, 0, 3'b010, 1, 1, 0);
    step(2, 3, 0, 3'b001, 0, 0, 3'b000, 0, 0, 0);
    step(2, 3, 0, 3'b001, 0, 0, 3'b001, 1, 0, 0);
    step(2, 3, 0, 3'b111, 0, 0, 3'b001, 1, 0, 0);
    step(2, 3, 0, 3'b110, 0, 0, 3'b000, 0, 0, 0);
    step(2, 3, 0, 3'b110, 0, 0, 3'b100, 1, 2, 0);
    step(2, 3, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
`ifdef WB_ARB_TIMEOUT_EN
    // watchdog expires on the 8th stalled cycle
    step(0, 5, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    step(0, 5, 0, 3'b010, 0, 0, 3'b010, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 5, 0, 3'b010, 1, 0, 3'b010, 1, 1, 0);
    step(0, 5, 0, 3'b010, 1, 0, 3'b010, 0, 1, 1);
    step(0, 5, 0, 3'b010, 1, 0, 3'b010, 0, 1, 0);
    step(0, 5, 0, 3'b010, 0, 0, 3'b010, 0, 1, 0);
    step(0, 5, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    // termination on the 8th cycle wins and restarts the count
    step(0, 5, 0, 3'b010, 0, 0, 3'b010, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 5, 0, 3'b010, 1, 0, 3'b010, 1, 1, 0);
    step(0, 5, 0, 3'b010, 1, 1, 3'b010, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 5, 0, 3'b010, 1, 0, 3'b010, 1, 1, 0);
    step(0, 5, 0, 3'b010, 1, 0, 3'b010, 0, 1, 1);
    step(0, 5, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
`else
    // without the watchdog a stalled owner keeps the bus
    step(0, 6, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    step(0, 6, 0, 3'b010, 0, 0, 3'b010, 1, 1, 0);
    for (int i = 0; i < 1000; i++) step(0, 6, 0, 3'b010, 1, 0, 3'b010, 1, 1, 0);
    step(0, 6, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
`endif
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
